// File: rtl/prng_pkg.sv
// Shared types and constants for the PRNG draw scheduler.
package prng_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSeed,
        StMix,
        StSample,
        StDeliver
    } state_e;

    localparam logic [15:0] LFSR_LOCKUP  = 16'hFFFF;
    localparam logic [15:0] SEED_DEFAULT = 16'hACE1;

    // An all-ones seed locks an XNOR LFSR, so swap in a known-good value.
    function automatic logic [15:0] seed_fix(input logic [15:0] val);
        return (val == LFSR_LOCKUP) ? SEED_DEFAULT : val;
    endfunction

endpackage

// File: rtl/prng_rr_arbiter.sv
// Round-robin pick among pending requesters, searching upward from ptr+1 with wrap.
module prng_rr_arbiter
    import prng_pkg::*;
#(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned PTR_W = 1
) (
    input  logic [NREQ-1:0]  pending,
    input  logic [PTR_W-1:0] ptr,
    output logic             arb_any,
    output logic [PTR_W-1:0] winner,
    output logic [NREQ-1:0]  winner_oh
);

    logic [PTR_W-1:0] idx;

    always_comb begin
        arb_any = 1'b0;
        winner  = '0;
        idx     = '0;
        for (int unsigned off = 1; off <= NREQ; off++) begin
            idx = PTR_W'((32'(ptr) + off) % NREQ);
            if (!arb_any && pending[idx]) begin
                arb_any = 1'b1;
                winner  = idx;
            end
        end
    end

    assign winner_oh = arb_any ? (NREQ'(1) << winner) : '0;

endmodule

// File: rtl/prng_draw_sched.sv
// Single-clock scheduler for the shared PRNG datapath: seeding, mixing, sampling and
// round-robin delivery of drawn bytes to NREQ requesters (requester 0 auto-fed by tick).
module prng_draw_sched
    import prng_pkg::*;
#(
    parameter int unsigned NREQ      = 2,
    parameter int unsigned TICK_DIV  = 10_000_000,
    parameter int unsigned MIX_STEPS = 8,
    parameter int unsigned CNT_W     = 24
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ena,
    input  logic            seed_req,
    input  logic [15:0]     seed_val,
    input  logic [NREQ-1:0] req,
    input  logic [7:0]      rnd_in,
    output logic            lfsr16_step,
    output logic            lfsr8_step,
    output logic            lfsr_load,
    output logic [15:0]     lfsr_seed,
    output logic [NREQ-1:0] gnt,
    output logic            rnd_valid,
    output logic [7:0]      rnd_out,
    output logic            tick,
    output logic            busy
);

    localparam int unsigned PTR_W = $clog2(NREQ);

    state_e           state_q;
    logic [CNT_W-1:0] presc_q;
    logic [NREQ-1:0]  pending_q, pending_d;
    logic             seed_pend_q, seed_pend_d;
    logic [PTR_W-1:0] ptr_q, winner_q;
    logic [7:0]       mix_cnt_q;

    logic             arb_any;
    logic [PTR_W-1:0] arb_winner;
    logic [NREQ-1:0]  arb_oh;

    prng_rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .pending   (pending_q),
        .ptr       (ptr_q),
        .arb_any   (arb_any),
        .winner    (arb_winner),
        .winner_oh (arb_oh)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            tick    <= 1'b0;
        end else if (!ena) begin
            presc_q <= '0;
            tick    <= 1'b0;
        end else if (presc_q == CNT_W'(TICK_DIV - 1)) begin
            presc_q <= '0;
            tick    <= 1'b1;
        end else begin
            presc_q <= presc_q + 1'b1;
            tick    <= 1'b0;
        end
    end

    // New requests are OR-ed in after the delivery clear, so a set always wins.
    always_comb begin
        pending_d = pending_q;
        if (rnd_valid) begin
            pending_d = pending_q & ~gnt;
        end
        pending_d = pending_d | req | NREQ'(tick);
        if (!ena) begin
            pending_d = '0;
        end
    end

    always_comb begin
        seed_pend_d = seed_req | (seed_pend_q & (state_q != StSeed));
        if (!ena) begin
            seed_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q   <= '0;
            seed_pend_q <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            seed_pend_q <= seed_pend_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            ptr_q       <= PTR_W'(NREQ - 1);
            winner_q    <= '0;
            mix_cnt_q   <= '0;
            lfsr16_step <= 1'b0;
            lfsr8_step  <= 1'b0;
            lfsr_load   <= 1'b0;
            lfsr_seed   <= '0;
            gnt         <= '0;
            rnd_valid   <= 1'b0;
            rnd_out     <= '0;
            busy        <= 1'b0;
        end else begin
            lfsr_load <= 1'b0;
            rnd_valid <= 1'b0;
            gnt       <= '0;
            if (!ena) begin
                state_q     <= StIdle;
                lfsr16_step <= 1'b0;
                lfsr8_step  <= 1'b0;
                busy        <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (seed_pend_q) begin
                            state_q   <= StSeed;
                            lfsr_load <= 1'b1;
                            lfsr_seed <= seed_fix(seed_val);
                            busy      <= 1'b1;
                        end else if (arb_any) begin
                            state_q     <= StMix;
                            winner_q    <= arb_winner;
                            mix_cnt_q   <= '0;
                            lfsr16_step <= 1'b1;
                            lfsr8_step  <= 1'b1;
                            busy        <= 1'b1;
                        end
                    end
                    StSeed: begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end
                    StMix: begin
                        if (mix_cnt_q == 8'(MIX_STEPS - 1)) begin
                            state_q     <= StSample;
                            lfsr16_step <= 1'b0;
                            lfsr8_step  <= 1'b0;
                        end else begin
                            mix_cnt_q <= mix_cnt_q + 1'b1;
                        end
                    end
                    StSample: begin
                        state_q   <= StDeliver;
                        rnd_out   <= rnd_in;
                        rnd_valid <= 1'b1;
                        gnt       <= NREQ'(1) << winner_q;
                    end
                    StDeliver: begin
                        state_q <= StIdle;
                        ptr_q   <= winner_q;
                        busy    <= 1'b0;
                    end
                    default: begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

    logic unused_oh;
    assign unused_oh = ^arb_oh;

endmodule
